// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/halfword/word loads and stores against a
// word-wide data memory with a combinational read port. Sub-word stores are
// done as read-modify-write. Byte lanes are big-endian within the word.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req, we, size,    request handshake and attributes, sampled only in IDLE
//   sext, addr, wdata
//   rdata             registered load result, held until the next good load
//   ready, err        one-cycle completion pulse / error pulse with ready
//   busy              high whenever the controller is not IDLE
//   dm_a, dm_we,      word-aligned address, write enable and write data to memory
//   dm_wd
//   dm_rd             combinational memory read data for dm_a
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 72
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [31:0] dm_a,
  output logic        dm_we,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] dm_a_q;
  logic        dm_we_q;
  logic [31:0] dm_wd_q;

  // Illegal size, misaligned access or address beyond the memory.
  function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
    logic bad;
    bad = (sz == 2'b11)
        | ((sz == SZ_HALF) & a[0])
        | ((sz == SZ_WORD) & (a[1:0] != 2'b00))
        | (a >= 32'(MEM_BYTES));
    return bad;
  endfunction

  // Pick the addressed lane out of the memory word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: r = {{24{sx & b[7]}}, b};
      SZ_HALF: r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the target lane of the old word with right-aligned store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[15:0]  = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Controller state and registered outputs; each output is set to its value
  // for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      dm_a_q  <= 32'h0;
      dm_we_q <= 1'b0;
      dm_wd_q <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dm_we_q <= 1'b0;
      dm_wd_q <= 32'h0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          dm_a_q <= 32'h0;
          if (req) begin
            off_q   <= addr[1:0];
            size_q  <= size;
            sext_q  <= sext;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            dm_a_q  <= {addr[31:2], 2'b00};
            if (is_illegal(size, addr)) begin
              state_q <= ERR;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (!we) begin
              state_q <= LOAD;
            end else if (size == SZ_WORD) begin
              state_q <= WRITE;
              dm_we_q <= 1'b1;
              dm_wd_q <= wdata;
            end else begin
              state_q <= READ;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_ext(dm_rd, off_q, size_q, sext_q);
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        READ: begin
          // The old word is captured here and merged straight into the write data.
          dm_wd_q <= merge(dm_rd, wdata_q, off_q, size_q);
          dm_we_q <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        DONE, ERR: begin
          busy_q  <= 1'b0;
          dm_a_q  <= 32'h0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          dm_a_q  <= 32'h0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign dm_a  = dm_a_q;
  assign dm_we = dm_we_q;
  assign dm_wd = dm_wd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with an 18-word behavioural data memory.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic [31:0] dm_a;
  logic        dm_we;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  logic [31:0] mem [0:17];

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.MEM_BYTES(72)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .size  (size),
    .sext  (sext),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .busy  (busy),
    .dm_a  (dm_a),
    .dm_we (dm_we),
    .dm_wd (dm_wd),
    .dm_rd (dm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rd = (dm_a < 32'd72) ? mem[dm_a[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (dm_we && (dm_a < 32'd72)) mem[dm_a[6:2]] <= dm_wd;
  end

  task automatic poke(input int unsigned idx, input logic [31:0] v);
    mem[idx] <= v;
    @(negedge clk);
  endtask

  // Issue one request; report the cycle (edges after acceptance) where ready
  // appeared, err at that point, and whether/what dm_we wrote on the way.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic err_s,
                           output logic we_s, output logic [31:0] wd_s);
    lat = 0; err_s = 1'b0; we_s = 1'b0; wd_s = 32'h0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (dm_we) begin we_s = 1'b1; wd_s = dm_wd; end
      if (ready) begin lat = e; err_s = err; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
    n_checks++; if ({ready, err, busy, dm_we} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {ready, err, busy, dm_we}); end
    n_checks++; if ({dm_a, dm_wd} !== 64'h0) begin n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", dm_a, dm_wd); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load;
    int lat; logic e_s, w_s; logic [31:0] wd;
    poke(2, 32'h11223344);
    poke(3, 32'h80FF1234);
    do_access(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ldb_latency got %0d want 2", lat); end
    n_checks++; if (rdata !== 32'h00000022) begin n_fail++; $display("FAIL ldb_0x09 got %h want 00000022", rdata); end
    n_checks++; if (e_s !== 1'b0 || w_s !== 1'b0) begin n_fail++; $display("FAIL ldb_flags got err=%b we=%b want 0 0", e_s, w_s); end
    do_access(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (rdata !== 32'h00000044) begin n_fail++; $display("FAIL ldb_0x0B got %h want 00000044", rdata); end
    do_access(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL ldh_sext got %h want ffff80ff", rdata); end
    do_access(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (rdata !== 32'h000080FF) begin n_fail++; $display("FAIL ldh_zext got %h want 000080ff", rdata); end
    do_access(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (rdata !== 32'h00001234) begin n_fail++; $display("FAIL ldh_low got %h want 00001234", rdata); end
    do_access(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL ldb_sext got %h want ffffffff", rdata); end
    poke(17, 32'h5A5A0001);
    do_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (rdata !== 32'h5A5A0001 || e_s !== 1'b0) begin n_fail++; $display("FAIL ldw_last got %h err=%b want 5a5a0001 0", rdata, e_s); end
    n_checks++; if (dm_a !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_bus got dm_a=%h busy=%b want 0 0", dm_a, busy); end
  endtask

  task automatic test_store;
    int lat; logic e_s, w_s; logic [31:0] wd;
    poke(4, 32'hAABBCCDD);
    do_access(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055, lat, e_s, w_s, wd);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL stb_latency got %0d want 3", lat); end
    n_checks++; if (w_s !== 1'b1 || wd !== 32'hAABB55DD) begin n_fail++; $display("FAIL stb_wd got we=%b wd=%h want 1 aabb55dd", w_s, wd); end
    n_checks++; if (mem[4] !== 32'hAABB55DD) begin n_fail++; $display("FAIL stb_mem got %h want aabb55dd", mem[4]); end
    n_checks++; if (rdata !== 32'h5A5A0001) begin n_fail++; $display("FAIL stb_rdata_hold got %h want 5a5a0001", rdata); end
    do_access(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, lat, e_s, w_s, wd);
    n_checks++; if (mem[4] !== 32'hBEEF55DD || lat !== 3) begin n_fail++; $display("FAIL sth_mem got %h lat=%0d want beef55dd 3", mem[4], lat); end
    do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF01, lat, e_s, w_s, wd);
    n_checks++; if (mem[4] !== 32'hBEEF5501) begin n_fail++; $display("FAIL stb_off3 got %h want beef5501", mem[4]); end
    do_access(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, lat, e_s, w_s, wd);
    n_checks++; if (lat !== 2 || mem[5] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stw got lat=%0d mem=%h want 2 cafef00d", lat, mem[5]); end
  endtask

  task automatic test_errors;
    int lat; logic e_s, w_s; logic [31:0] wd;
    do_access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (lat !== 1 || e_s !== 1'b1 || w_s !== 1'b0) begin n_fail++; $display("FAIL err_misalign got lat=%0d err=%b we=%b want 1 1 0", lat, e_s, w_s); end
    n_checks++; if (rdata !== 32'h5A5A0001) begin n_fail++; $display("FAIL err_rdata got %h want 5a5a0001", rdata); end
    do_access(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, lat, e_s, w_s, wd);
    n_checks++; if (lat !== 1 || e_s !== 1'b1 || w_s !== 1'b0) begin n_fail++; $display("FAIL err_range got lat=%0d err=%b we=%b want 1 1 0", lat, e_s, w_s); end
    poke(0, 32'h0BADF00D);
    do_access(1'b1, 2'b11, 1'b0, 32'h00, 32'h12345678, lat, e_s, w_s, wd);
    n_checks++; if (lat !== 1 || e_s !== 1'b1 || w_s !== 1'b0 || mem[0] !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_size got lat=%0d err=%b we=%b mem=%h want 1 1 0 0badf00d", lat, e_s, w_s, mem[0]); end
    do_access(1'b1, 2'b01, 1'b0, 32'h01, 32'h12345678, lat, e_s, w_s, wd);
    n_checks++; if (e_s !== 1'b1 || w_s !== 1'b0 || mem[0] !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_half_odd got err=%b we=%b mem=%h want 1 0 0badf00d", e_s, w_s, mem[0]); end
    n_checks++; if (rdata !== 32'h5A5A0001) begin n_fail++; $display("FAIL err_rdata2 got %h want 5a5a0001", rdata); end
  endtask

  task automatic test_reset_abort;
    poke(6, 32'h01020304);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b01; sext = 1'b0; addr = 32'h18; wdata = 32'h0000FFFF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n_checks++; if (busy !== 1'b1 || dm_we !== 1'b0) begin n_fail++; $display("FAIL abort_in_read got busy=%b we=%b want 1 0", busy, dm_we); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || dm_we !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL abort_state got busy=%b we=%b ready=%b rdata=%h want 0 0 0 0", busy, dm_we, ready, rdata); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (mem[6] !== 32'h01020304 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_mem got %h busy=%b want 01020304 0", mem[6], busy); end
    // Reset and a valid request on the same edge: reset must win.
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h18; wdata = 32'hDEADBEEF; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_prio got busy=%b we=%b want 0 0", busy, dm_we); end
    repeat (3) @(negedge clk);
    n_checks++; if (mem[6] !== 32'h01020304) begin n_fail++; $display("FAIL reset_prio_mem got %h want 01020304", mem[6]); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] rdy_mask;
    logic [8:0] we_mask;
    rdy_mask = 9'b0;
    we_mask  = 9'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h20; wdata = 32'h00000000;
    @(posedge clk);
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      rdy_mask[e-1] = ready;
      we_mask[e-1]  = dm_we;
      // Distinct data per cycle; only the value present at each IDLE edge lands.
      wdata = 32'(e);
    end
    req = 1'b0;
    n_checks++; if (rdy_mask !== 9'b010010010) begin n_fail++; $display("FAIL b2b_ready got %b want 010010010", rdy_mask); end
    n_checks++; if (we_mask !== 9'b001001001) begin n_fail++; $display("FAIL b2b_we got %b want 001001001", we_mask); end
    repeat (4) @(negedge clk);
    n_checks++; if (mem[8] !== 32'h00000006 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_mem got %h busy=%b want 00000006 0", mem[8], busy); end
  endtask

  initial begin
    for (int i = 0; i < 18; i++) mem[i] = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 72, the data memory size in bytes (18 words).
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  1  access request from the datapath, sampled only in IDLE.
REQ-005 The block SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 The block SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-007 The block SHALL have port sext  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-008 The block SHALL have port addr  input  32  byte address.
REQ-009 The block SHALL have port wdata  input  32  store data, right-aligned for sub-word stores.
REQ-010 The block SHALL have port rdata  output  32  registered load result.
REQ-011 The block SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port err  output  1  one-cycle error pulse, coincident with ready.
REQ-013 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 The block SHALL have port dm_a  output  32  word-aligned address to the data memory.
REQ-015 The block SHALL have port dm_we  output  1  data memory write enable.
REQ-016 The block SHALL have port dm_wd  output  32  data memory write data.
REQ-017 The block SHALL have port dm_rd  input  32  combinational data memory read data.

Function
REQ-018 The block SHALL implement states IDLE, LOAD, READ, WRITE, ERR and DONE.
REQ-019 In IDLE with req=1, the block SHALL latch addr, we, size, sext and wdata at the clock edge; it SHALL ignore req in every other state.
REQ-020 Requests with size=11, a halfword with addr[0]=1, a word with addr[1:0]!=0, or addr>=MEM_BYTES SHALL go IDLE->ERR; ERR SHALL assert ready=1 and err=1 for one cycle, never assert dm_we, then return to IDLE.
REQ-021 A valid load SHALL follow IDLE->LOAD->DONE; in LOAD, the block SHALL register the extracted and extended dm_rd into rdata.
REQ-022 A valid word store SHALL follow IDLE->WRITE->DONE; in WRITE, dm_we=1 and dm_wd=wdata.
REQ-023 A valid byte or halfword store SHALL follow IDLE->READ->WRITE->DONE; in READ, the block SHALL capture dm_rd; in WRITE, dm_we=1 and dm_wd is the captured word with only the target lane replaced.
REQ-024 DONE SHALL assert ready=1 and err=0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-025 With req accepted at edge k, ready SHALL be high in cycle k+2 for loads, word stores and errors (error: k+1), and in cycle k+3 for sub-word stores.
REQ-026 Byte lanes SHALL be big-endian: offset 0 maps to bits 31:24 and offset 3 to bits 7:0; halfword offset 0 maps to bits 31:16 and offset 2 to bits 15:0.
REQ-027 dm_a SHALL equal {latched addr[31:2],2'b00} outside IDLE and 0 in IDLE; dm_we SHALL be high only in WRITE.
REQ-028 rdata SHALL hold its value until the next successful load, and SHALL be unchanged by stores and errors.
REQ-029 busy SHALL be low only in IDLE, so a new req is accepted in the cycle after DONE or ERR at the earliest.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL force state to IDLE and set rdata=0, ready=0, err=0, busy=0, dm_we=0, dm_a=0 and dm_wd=0.
REQ-031 Reset SHALL abort any in-flight access, including the READ or WRITE states, and no dm_we SHALL be asserted in the cycle following reset.
REQ-032 Reset SHALL take priority over req when both are sampled at the same edge.

Verification
REQ-033 Word at 0x08 = 0x11223344; load byte addr 0x09 with sext=0 -> ready at k+2, rdata=0x00000022.
REQ-034 Word at 0x0C = 0x80FF1234; load half addr 0x0C with sext=1 -> rdata=0xFFFF80FF; with sext=0 -> rdata=0x000080FF.
REQ-035 Word at 0x10 = 0xAABBCCDD; store byte wdata=0x00000055 at addr 0x12 -> READ, then WRITE with dm_wd=0xAABB55DD, ready at k+3.
REQ-036 Load word at addr 0x06, and separately at addr 0x48 -> ERR at k+1, ready=err=1, dm_we never asserted, rdata unchanged.
REQ-037 Assert reset during the READ state of a halfword store -> next cycle state IDLE, dm_we=0, memory word unchanged.
REQ-038 Hold req=1 continuously with back-to-back word stores -> exactly one access per IDLE visit, ready pulses at k+2, k+5, k+8.
